// File: rtl/cordic_scheduler_pkg.sv
// Shared settings for the CORDIC scheduler: data width, default requester count, kernel latency and tag type.
// The optional per-requester grant counters are enabled with CORDIC_SCHEDULER_STATS_EN.
package cordic_scheduler_pkg;

  localparam int SIZE_DATA      = 16;
  localparam int NUM_CORDIC_REQ = 4;
  localparam int CORDIC_LATENCY = 16;

  // Tag width never collapses to zero bits, even with a single requester.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int ID_W = id_width(NUM_CORDIC_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } cordic_tag_t;

endpackage

// File: rtl/cordic_scheduler_rr_arbiter.sv
// Round-robin arbiter for the CORDIC scheduler; owns the rotating priority pointer.
module rr_arbiter #(
  parameter int NUM_REQ = cordic_scheduler_pkg::NUM_CORDIC_REQ,
  parameter int ID_W    = cordic_scheduler_pkg::id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);
  import cordic_scheduler_pkg::*;

  logic [ID_W-1:0] rrPtr_q;
  logic [ID_W-1:0] rrPtr_d;
  logic            found;
  int              idx;

  // Search upward from the pointer, wrapping once; the pointer never exceeds NUM_REQ-1.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    grant_any = found & enable;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (grant_any) begin
      if (int'(grant_idx) == NUM_REQ - 1) begin
        rrPtr_d = '0;
      end else begin
        rrPtr_d = grant_idx + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one pipelined CORDIC kernel between NUM_REQ requesters with tagged responses.
// Define CORDIC_SCHEDULER_STATS_EN to add saturating per-requester grant counters (grant_count).
module cordic_scheduler #(
  parameter int NUM_REQ        = cordic_scheduler_pkg::NUM_CORDIC_REQ,
  parameter int CORDIC_LATENCY = cordic_scheduler_pkg::CORDIC_LATENCY,
  parameter int ID_W           = cordic_scheduler_pkg::id_width(NUM_REQ)
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             enable,
  input  logic [NUM_REQ-1:0]                               req_valid,
  input  logic [NUM_REQ*cordic_scheduler_pkg::SIZE_DATA-1:0] req_data,
  output logic [NUM_REQ-1:0]                               req_ready,
  output logic [cordic_scheduler_pkg::SIZE_DATA-1:0]       cordic_input_data,
  input  logic signed [cordic_scheduler_pkg::SIZE_DATA-1:0] cordic_output_data,
  output logic                                             resp_valid,
  output logic [ID_W-1:0]                                  resp_id,
  output logic signed [cordic_scheduler_pkg::SIZE_DATA-1:0] resp_data,
  output logic                                             busy
`ifdef CORDIC_SCHEDULER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]                            grant_count
`endif
);
  import cordic_scheduler_pkg::*;

  // Entry 0 travels with the issue register; entries 1..LATENCY mirror the kernel stages.
  localparam int TAG_STAGES = CORDIC_LATENCY + 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grantIdx;
  logic                   grantAny;

  logic [SIZE_DATA-1:0]   issueData_d;
  logic [SIZE_DATA-1:0]   issueData_q;
  tag_t                   issueTag_d;
  tag_t                   tagPipe_q [TAG_STAGES];

  logic                   respValid_q;
  logic [ID_W-1:0]        respId_q;
  logic signed [SIZE_DATA-1:0] respData_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req_valid (req_valid),
    .grant     (grant),
    .grant_idx (grantIdx),
    .grant_any (grantAny)
  );

  assign req_ready = grant;

  always_comb begin
    issueData_d      = '0;
    issueTag_d       = '0;
    if (grantAny) begin
      issueData_d      = req_data[int'(grantIdx)*SIZE_DATA +: SIZE_DATA];
      issueTag_d.valid = 1'b1;
      issueTag_d.id    = grantIdx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issueData_q <= '0;
    end else begin
      issueData_q <= issueData_d;
    end
  end

  assign cordic_input_data = issueData_q;

  // The tag pipe never stalls, so a reset simply discards every in-flight tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAG_STAGES; i++) begin
        tagPipe_q[i] <= '0;
      end
    end else begin
      tagPipe_q[0] <= issueTag_d;
      for (int i = 1; i < TAG_STAGES; i++) begin
        tagPipe_q[i] <= tagPipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      respValid_q <= 1'b0;
      respId_q    <= '0;
      respData_q  <= '0;
    end else begin
      respValid_q <= tagPipe_q[TAG_STAGES-1].valid;
      if (tagPipe_q[TAG_STAGES-1].valid) begin
        respId_q   <= tagPipe_q[TAG_STAGES-1].id;
        respData_q <= cordic_output_data;
      end
    end
  end

  assign resp_valid = respValid_q;
  assign resp_id    = respId_q;
  assign resp_data  = respData_q;

  always_comb begin
    busy = respValid_q;
    for (int i = 0; i < TAG_STAGES; i++) begin
      busy = busy | tagPipe_q[i].valid;
    end
  end

`ifdef CORDIC_SCHEDULER_STATS_EN
  logic [15:0] grantCount_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grantCount_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (grantCount_q[i] != 16'hFFFF)) begin
          grantCount_q[i] <= grantCount_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_count[i*16 +: 16] = grantCount_q[i];
    end
  end
`endif

endmodule
